// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// mux select codes and the control-word payload.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LOAD_WB   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_retired;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath-facing bundle of the control sequencer: status inputs from the
// datapath/memory and the control strobes/selects driven back.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic               instr_retired;
    logic [CNT_W-1:0]   retired_count;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_retired, retired_count, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_retired, retired_count, state
    );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Moore control-word decode: maps the current state (plus mem_ready/zero where
// a strobe is qualified by them) to the datapath control outputs.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_LOAD_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.mem_to_reg    = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            // A store only retires on the cycle memory accepts it.
            S_MEM_WRITE: begin
                ctrl.mem_write     = 1'b1;
                ctrl.iord          = 1'b1;
                ctrl.instr_retired = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.reg_dst       = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write      = zero;
                ctrl.instr_retired = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source     = PCSRC_JUMP;
                ctrl.pc_write      = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: state register, opcode dispatch and the
// retired-instruction counter; the control word comes from mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl;
    ctrl_t            ctrl_g;
    logic             illegal;

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .zero      (bus.zero),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl.instr_retired) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state dispatch; unknown opcodes fall back to FETCH from DECODE.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = bus.mem_ready ? S_LOAD_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    assign illegal = (state_q == S_DECODE) && !is_legal_op(bus.opcode);

    // Every output is held low while reset is asserted.
    assign ctrl_g = rst ? '0 : ctrl;

    assign bus.pc_write      = ctrl_g.pc_write;
    assign bus.iord          = ctrl_g.iord;
    assign bus.mem_read      = ctrl_g.mem_read;
    assign bus.mem_write     = ctrl_g.mem_write;
    assign bus.ir_write      = ctrl_g.ir_write;
    assign bus.reg_dst       = ctrl_g.reg_dst;
    assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
    assign bus.reg_write     = ctrl_g.reg_write;
    assign bus.alu_src_a     = ctrl_g.alu_src_a;
    assign bus.alu_src_b     = ctrl_g.alu_src_b;
    assign bus.alu_op        = ctrl_g.alu_op;
    assign bus.pc_source     = ctrl_g.pc_source;
    assign bus.instr_retired = ctrl_g.instr_retired;
    assign bus.illegal_op    = illegal & ~rst;
    assign bus.retired_count = rst ? '0 : count_q;
    assign bus.state         = rst ? '0 : STATE_W'(state_q);

endmodule
